// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: word types, operation codes and FSM states.
package hilo_muldiv_unit_pkg;

    localparam int WIDTH_REG = 32;
    localparam int DIV_ITERS = WIDTH_REG;
    localparam int COUNT_W   = $clog2(DIV_ITERS) + 1;

    typedef logic [WIDTH_REG-1:0]   word_t;
    typedef logic [2*WIDTH_REG-1:0] double_word_t;

    typedef enum logic [2:0] {
        ALU_NOP  = 3'd0,
        ALU_MULT = 3'd1,
        ALU_DIV  = 3'd2
    } mult_op_enum;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} muldiv_state_enum;

    // Two's-complement magnitude; unsigned operands pass through untouched.
    function automatic word_t magnitude(input word_t v, input logic is_signed);
        return (is_signed && v[WIDTH_REG-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between decode/EX and the multiply/divide unit.
interface hilo_muldiv_unit_if;
    import hilo_muldiv_unit_pkg::*;

    logic        start_i;
    mult_op_enum op_i;
    logic        sign_i;
    word_t       src_a_i;
    word_t       src_b_i;
    logic        flush_i;
    logic        hi_we_i;
    logic        lo_we_i;
    word_t       mt_data_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    word_t       hi_o;
    word_t       lo_o;

    modport master (
        output start_i, op_i, sign_i, src_a_i, src_b_i, flush_i, hi_we_i, lo_we_i, mt_data_i,
        input  busy_o, done_o, error_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, sign_i, src_a_i, src_b_i, flush_i, hi_we_i, lo_we_i, mt_data_i,
        output busy_o, done_o, error_o, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_unit_restoring_div_core.sv
// Unsigned restoring divider: one quotient bit per step, MSB first, on magnitudes supplied by the unit.
module restoring_div_core
    import hilo_muldiv_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  step,
    input  word_t dividend,
    input  word_t divisor,
    output word_t quotient,
    output word_t remainder,
    output logic  last
);

    word_t              rem_q;
    word_t              quo_q;
    word_t              div_q;
    logic [COUNT_W-1:0] count_q;

    logic [WIDTH_REG:0] shifted;
    word_t              diff;
    logic               take;

    // The partial remainder stays below the divisor, so one extra bit covers the shift.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH_REG-1]};
        take    = (shifted >= {1'b0, div_q});
        diff    = shifted[WIDTH_REG-1:0] - div_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            div_q   <= divisor;
            count_q <= '0;
        end else if (step) begin
            rem_q   <= take ? diff : shifted[WIDTH_REG-1:0];
            quo_q   <= {quo_q[WIDTH_REG-2:0], take};
            count_q <= count_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (count_q == COUNT_W'(DIV_ITERS));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; busy_o stalls the pipeline during an op.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    hilo_muldiv_unit_if.slave bus
);

    muldiv_state_enum state_q, state_d;
    word_t            hi_q, lo_q, a_q, b_q;
    logic             sign_q, error_q;

    logic             busy, op_valid, accept;
    logic             div_load, div_step, div_last, commit_mul, commit_div;
    word_t            div_quo, div_rem, quo_fix, rem_fix;
    double_word_t     ext_a, ext_b, product;

    restoring_div_core u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (magnitude(bus.src_a_i, bus.sign_i)),
        .divisor   (magnitude(bus.src_b_i, bus.sign_i)),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // Flush outranks every transition and also suppresses a coincident start.
    always_comb begin
        busy       = (state_q == MD_MUL) || (state_q == MD_DIV);
        op_valid   = (bus.op_i == ALU_MULT) || (bus.op_i == ALU_DIV);
        accept     = bus.start_i && op_valid && !bus.flush_i && !busy;
        div_load   = accept && (bus.op_i == ALU_DIV);
        div_step   = (state_q == MD_DIV) && !div_last && !bus.flush_i;
        commit_mul = (state_q == MD_MUL) && !bus.flush_i;
        commit_div = (state_q == MD_DIV) && div_last && !bus.flush_i;
        state_d    = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = (bus.op_i == ALU_MULT) ? MD_MUL : MD_DIV;
            MD_MUL:  state_d = MD_DONE;
            MD_DIV:  if (div_last) state_d = MD_DONE;
            MD_DONE: state_d = accept ? ((bus.op_i == ALU_MULT) ? MD_MUL : MD_DIV) : MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (bus.flush_i) state_d = MD_IDLE;
    end

    // Quotient sign follows the operand signs; remainder follows the dividend.
    always_comb begin
        ext_a   = sign_q ? {{WIDTH_REG{a_q[WIDTH_REG-1]}}, a_q} : {{WIDTH_REG{1'b0}}, a_q};
        ext_b   = sign_q ? {{WIDTH_REG{b_q[WIDTH_REG-1]}}, b_q} : {{WIDTH_REG{1'b0}}, b_q};
        product = ext_a * ext_b;
        quo_fix = (sign_q && (a_q[WIDTH_REG-1] ^ b_q[WIDTH_REG-1])) ? -div_quo : div_quo;
        rem_fix = (sign_q && a_q[WIDTH_REG-1]) ? -div_rem : div_rem;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= commit_div && (b_q == '0);
            if (accept) begin
                a_q    <= bus.src_a_i;
                b_q    <= bus.src_b_i;
                sign_q <= bus.sign_i;
            end
            if (commit_mul) begin
                hi_q <= product[2*WIDTH_REG-1:WIDTH_REG];
                lo_q <= product[WIDTH_REG-1:0];
            end else if (commit_div) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else if (!busy) begin
                if (bus.hi_we_i) hi_q <= bus.mt_data_i;
                if (bus.lo_we_i) lo_q <= bus.mt_data_i;
            end
        end
    end

    assign bus.busy_o  = busy;
    assign bus.done_o  = (state_q == MD_DONE);
    assign bus.error_o = error_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: directed cases plus random traffic against a transaction-level HI/LO model.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic cmp_on;
    int   total;
    int   bad;

    hilo_muldiv_unit_if bus();

    hilo_muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: result becomes visible a fixed number of edges after acceptance.
    logic  exp_busy, exp_done, exp_err;
    word_t exp_hi, exp_lo;
    int    m_rem;
    word_t p_hi, p_lo;
    logic  p_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input word_t dut_v, input word_t model_v, input word_t lit);
        check({name, "_dut"}, dut_v, lit);
        check({name, "_model"}, model_v, lit);
    endtask

    task automatic compute_result(input mult_op_enum op, input logic sg, input word_t a, input word_t b);
        longint       sa, sb, q, r;
        logic [63:0]  prod;
        word_t        mag;
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if (op == ALU_MULT) begin
            prod  = sa * sb;
            p_hi  = prod[63:32];
            p_lo  = prod[31:0];
            p_err = 1'b0;
        end else if (b == 32'h0) begin
            mag   = (sg && a[31]) ? -a : a;
            p_lo  = (sg && a[31]) ? -32'hFFFF_FFFF : 32'hFFFF_FFFF;
            p_hi  = (sg && a[31]) ? -mag : mag;
            p_err = 1'b1;
        end else begin
            if (sg) begin
                q    = sa / sb;
                r    = sa % sb;
                p_lo = word_t'(q);
                p_hi = word_t'(r);
            end else begin
                p_lo = a / b;
                p_hi = a % b;
            end
            p_err = 1'b0;
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            exp_busy = 0; exp_done = 0; exp_err = 0; exp_hi = 0; exp_lo = 0; m_rem = 0;
        end else if (bus.flush_i) begin
            if (!exp_busy) begin
                if (bus.hi_we_i) exp_hi = bus.mt_data_i;
                if (bus.lo_we_i) exp_lo = bus.mt_data_i;
            end
            exp_busy = 0; exp_done = 0; exp_err = 0;
        end else if (exp_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                exp_busy = 0; exp_done = 1; exp_err = p_err; exp_hi = p_hi; exp_lo = p_lo;
            end
        end else begin
            if (bus.hi_we_i) exp_hi = bus.mt_data_i;
            if (bus.lo_we_i) exp_lo = bus.mt_data_i;
            exp_done = 0; exp_err = 0;
            if (bus.start_i && (bus.op_i == ALU_MULT || bus.op_i == ALU_DIV)) begin
                compute_result(bus.op_i, bus.sign_i, bus.src_a_i, bus.src_b_i);
                exp_busy = 1;
                m_rem    = (bus.op_i == ALU_MULT) ? 1 : DIV_ITERS + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    // Single compare point, half a cycle after each model update.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("busy", 32'(bus.busy_o), 32'(exp_busy));
            check("done", 32'(bus.done_o), 32'(exp_done));
            check("error", 32'(bus.error_o), 32'(exp_err));
            check("hi", bus.hi_o, exp_hi);
            check("lo", bus.lo_o, exp_lo);
        end
    end

    task automatic idle_inputs();
        bus.start_i = 0; bus.op_i = ALU_NOP; bus.sign_i = 0; bus.src_a_i = 0; bus.src_b_i = 0;
        bus.flush_i = 0; bus.hi_we_i = 0; bus.lo_we_i = 0; bus.mt_data_i = 0;
    endtask

    task automatic launch(input mult_op_enum op, input logic sg, input word_t a, input word_t b);
        bus.start_i = 1; bus.op_i = op; bus.sign_i = sg; bus.src_a_i = a; bus.src_b_i = b;
        tick();
        bus.start_i = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done_o && lat < 60) begin
            tick();
            lat++;
        end
        check("done_timeout", 32'(bus.done_o), 32'd1);
    endtask

    task automatic applyStimulus(input mult_op_enum op, input logic sg, input word_t a, input word_t b,
                                 output int lat);
        launch(op, sg, a, b);
        wait_done(lat);
    endtask

    task automatic checkOutput(input string name, input word_t hi, input word_t lo, input logic err);
        pin({name, "_hi"}, bus.hi_o, exp_hi, hi);
        pin({name, "_lo"}, bus.lo_o, exp_lo, lo);
        check({name, "_err"}, 32'(bus.error_o), 32'(err));
    endtask

    function automatic word_t pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return word_t'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int r;
        total = 0; bad = 0; cmp_on = 0;
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        cmp_on = 1;
        checkOutput("reset", 32'h0, 32'h0, 1'b0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);

        applyStimulus(ALU_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3, lat);
        check("mult_latency", 32'(lat), 32'd2);
        checkOutput("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        tick();
        applyStimulus(ALU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checkOutput("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        tick();
        applyStimulus(ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_latency", 32'(lat), 32'd34);
        checkOutput("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        tick();
        applyStimulus(ALU_DIV, 1'b0, 32'd7, 32'd2, lat);
        checkOutput("divu_7_2", 32'd1, 32'd3, 1'b0);
        tick();
        applyStimulus(ALU_DIV, 1'b0, 32'd7, 32'd0, lat);
        checkOutput("divu_by_zero", 32'd7, 32'hFFFF_FFFF, 1'b1);
        tick();
        applyStimulus(ALU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checkOutput("div_overflow", 32'h0, 32'h8000_0000, 1'b0);
        tick();

        launch(ALU_DIV, 1'b0, 32'd7, 32'd2);
        bus.hi_we_i = 1; bus.mt_data_i = 32'h1234;
        tick();
        bus.hi_we_i = 0;
        wait_done(lat);
        checkOutput("mthi_busy", 32'd1, 32'd3, 1'b0);
        tick();
        bus.lo_we_i = 1; bus.mt_data_i = 32'h55;
        tick();
        bus.lo_we_i = 0;
        pin("mtlo_idle", bus.lo_o, exp_lo, 32'h55);

        bus.hi_we_i = 1; bus.lo_we_i = 1; bus.mt_data_i = 32'hAAAA;
        tick();
        bus.hi_we_i = 0; bus.lo_we_i = 0;
        launch(ALU_DIV, 1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        bus.flush_i = 1;
        tick();
        bus.flush_i = 0;
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("flush", 32'hAAAA, 32'hAAAA, 1'b0);
        repeat (3) tick();
        check("flush_no_done", 32'(bus.done_o), 32'd0);

        launch(ALU_MULT, 1'b0, 32'd5, 32'd6);
        rst_n = 0;
        tick();
        rst_n = 1;
        checkOutput("reset_mid_mul", 32'h0, 32'h0, 1'b0);
        check("reset_mid_busy", 32'(bus.busy_o), 32'd0);
        check("reset_mid_done", 32'(bus.done_o), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            bus.start_i = ($urandom_range(0, 99) < 30);
            r = $urandom_range(0, 9);
            bus.op_i    = (r < 4) ? ALU_MULT : (r < 8) ? ALU_DIV : mult_op_enum'(3'($urandom_range(3, 7)));
            bus.sign_i  = 1'($urandom_range(0, 1));
            bus.src_a_i = pick_operand();
            bus.src_b_i = pick_operand();
            bus.hi_we_i = ($urandom_range(0, 4) == 0);
            bus.lo_we_i = ($urandom_range(0, 4) == 0);
            bus.mt_data_i = word_t'($urandom);
            bus.flush_i = ($urandom_range(0, 199) == 0);
            rst_n       = !($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        rst_n = 1;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
